// File: rtl/fb_pixel_writer_if.sv
// Pixel stream into the frame-buffer writer: valid/ready handshake with a start-of-frame marker.
`timescale 1ns/1ps
interface fb_pixel_writer_if;
    logic       s_valid;
    logic       s_sof;
    logic [8:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_sof, output s_data, input s_ready);
    modport slave  (input s_valid, input s_sof, input s_data, output s_ready);
endinterface

// File: rtl/fb_pixel_writer.sv
// Write side of the RGB frame buffer: turns a raster-ordered pixel stream into RAM writes
// at addr = y*H_PIX + x, using an incremental address counter instead of a multiplier.
`timescale 1ns/1ps
module fb_pixel_writer #(
    parameter int H_PIX  = 400,
    parameter int V_PIX  = 300,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    fb_pixel_writer_if.slave  s_if,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [2:0]        ram_red,
    output logic [2:0]        ram_green,
    output logic [2:0]        ram_blue,
    output logic              busy,
    output logic              frame_done,
    output logic              sof_err
);
    localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_PIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_s;
    logic              accept_s;

    // Ready is combinational in enable and rst_n so a stall or reset blocks acceptance in the same cycle.
    assign ready_s  = enable & rst_n & (state_q != ST_DONE);
    assign accept_s = s_if.s_valid & ready_s;
    assign s_if.s_ready = ready_s;

    // Next-state, counter and write-port computation.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && s_if.s_sof) begin
                    we_d    = 1'b1;
                    addr_d  = {ADDR_W{1'b0}};
                    data_d  = s_if.s_data;
                    x_d     = XW'(1);
                    y_d     = {YW{1'b0}};
                    cnt_d   = ADDR_W'(1);
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (accept_s) begin
                    we_d   = 1'b1;
                    data_d = s_if.s_data;
                    if (s_if.s_sof) begin
                        // Resync: restart the frame at the origin without reporting completion.
                        err_d  = 1'b1;
                        addr_d = {ADDR_W{1'b0}};
                        x_d    = XW'(1);
                        y_d    = {YW{1'b0}};
                        cnt_d  = ADDR_W'(1);
                    end else begin
                        addr_d = cnt_q;
                        cnt_d  = cnt_q + ADDR_W'(1);
                        if (x_q == X_LAST) begin
                            x_d = {XW{1'b0}};
                            if (y_q == Y_LAST) begin
                                y_d     = {YW{1'b0}};
                                cnt_d   = {ADDR_W{1'b0}};
                                done_d  = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                y_d = y_q + YW'(1);
                            end
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                x_d     = {XW{1'b0}};
                y_d     = {YW{1'b0}};
                cnt_d   = {ADDR_W{1'b0}};
                state_d = ST_IDLE;
            end
            default: begin
                x_d     = {XW{1'b0}};
                y_d     = {YW{1'b0}};
                cnt_d   = {ADDR_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_WRITE);
    end

    // State, counters and registered outputs; reset clears the write strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= {XW{1'b0}};
            y_q     <= {YW{1'b0}};
            cnt_q   <= {ADDR_W{1'b0}};
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= 9'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_red    = data_q[8:6];
    assign ram_green  = data_q[5:3];
    assign ram_blue   = data_q[2:0];
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign sof_err    = err_q;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Randomized bench for fb_pixel_writer with a linear-index frame model checked every cycle.
`timescale 1ns/1ps
module tb_fb_pixel_writer;
    localparam int H  = 400;
    localparam int V  = 8;
    localparam int N  = H * V;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [2:0]    ram_red, ram_green, ram_blue;
    logic          busy, frame_done, sof_err;

    fb_pixel_writer_if sif ();

    fb_pixel_writer #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .s_if       (sif),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_red    (ram_red),
        .ram_green  (ram_green),
        .ram_blue   (ram_blue),
        .busy       (busy),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: m_pos is the linear index of the next pixel in the frame, -1 while waiting for sof.
    int         m_pos;
    bit         m_done, m_we, m_fd, m_err;
    int         m_addr;
    logic [8:0] m_data;
    int         acc_cnt = 0;

    int dut_wr = 0, dut_fd = 0, dut_err = 0, rdy_low = 0, wr_in_frame = 0;
    bit chk401 = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = -1; m_done = 1'b0; m_we = 1'b0; m_fd = 1'b0; m_err = 1'b0;
        m_addr = 0; m_data = 9'd0;
    endtask

    task automatic model_step();
        bit acc;
        acc  = sif.s_valid && enable && !m_done;
        m_we = 1'b0; m_fd = 1'b0; m_err = 1'b0;
        if (m_done) begin
            m_done = 1'b0;
            m_pos  = -1;
        end else if (acc) begin
            acc_cnt++;
            if (sif.s_sof) begin
                m_err = (m_pos >= 0);
                m_we = 1'b1; m_addr = 0; m_data = sif.s_data; m_pos = 1;
            end else if (m_pos >= 0) begin
                m_we = 1'b1; m_addr = m_pos; m_data = sif.s_data; m_pos++;
                if (m_pos == N) begin
                    m_fd = 1'b1; m_done = 1'b1; m_pos = -1;
                end
            end
        end
    endtask

    // Model advance on the active edge, comparison on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset(); else model_step();
            @(negedge clk);
            if (!rst_n) model_reset();
            check("s_ready", int'(sif.s_ready), (enable && rst_n && !m_done) ? 1 : 0);
            check("ram_we", int'(ram_we), int'(m_we));
            check("busy", int'(busy), (m_pos >= 0) ? 1 : 0);
            check("frame_done", int'(frame_done), int'(m_fd));
            check("sof_err", int'(sof_err), int'(m_err));
            check("ram_addr", int'(ram_addr), m_addr);
            check("ram_rgb", int'({ram_red, ram_green, ram_blue}), int'(m_data));
            if (ram_we) begin
                dut_wr++;
                wr_in_frame++;
                if (chk401 && wr_in_frame == 401) check("addr_401st_write", int'(ram_addr), 400);
            end
            if (frame_done) dut_fd++;
            if (sof_err) dut_err++;
            if (enable && !sif.s_ready) rdy_low++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sof, input logic [8:0] d);
        int start;
        start = acc_cnt;
        sif.s_valid = 1'b1; sif.s_sof = sof; sif.s_data = d; enable = 1'b1;
        for (int i = 0; i < 20 && acc_cnt == start; i++) tick();
        sif.s_valid = 1'b0; sif.s_sof = 1'b0;
        check("send_accepted", acc_cnt - start, 1);
    endtask

    task automatic run_frame(input int vpct, input int epct);
        int start, idx, cyc;
        start = acc_cnt; cyc = 0;
        while ((acc_cnt - start) < N && cyc < 30000) begin
            idx = acc_cnt - start;
            sif.s_valid = ($urandom_range(99) < vpct);
            sif.s_sof   = (idx == 0);
            sif.s_data  = idx[8:0];
            enable      = ($urandom_range(99) < epct);
            tick();
            cyc++;
        end
        sif.s_valid = 1'b0; sif.s_sof = 1'b0; enable = 1'b1;
        check("frame_accept_count", acc_cnt - start, N);
    endtask

    int w0, fd0, e0;

    initial begin
        rst_n = 1'b0; enable = 1'b0;
        sif.s_valid = 1'b0; sif.s_sof = 1'b0; sif.s_data = 9'd0;
        repeat (3) tick();
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_s_ready", int'(sif.s_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_addr", int'(ram_addr), 0);
        rst_n = 1'b1;
        tick();

        // Pixels without sof while idle are dropped; the sof pixel lands at 0.
        w0 = dut_wr;
        for (int i = 0; i < 5; i++) send(1'b0, 9'($urandom_range(511)));
        tick();
        check("idle_discard_writes", dut_wr - w0, 0);
        send(1'b1, 9'h1FF);
        check("sof_we", int'(ram_we), 1);
        check("sof_addr", int'(ram_addr), 0);
        check("sof_rgb", int'({ram_red, ram_green, ram_blue}), 9'o777);
        check("model_sof_addr", m_addr, 0);

        // End of the first line and wrap to the second.
        for (int i = 1; i < 399; i++) send(1'b0, 9'($urandom_range(511)));
        send(1'b0, 9'b101_010_001);
        check("x399_addr", int'(ram_addr), 399);
        check("x399_red", int'(ram_red), 5);
        check("x399_green", int'(ram_green), 2);
        check("x399_blue", int'(ram_blue), 1);
        check("model_x399_addr", m_addr, 399);
        send(1'b0, 9'($urandom_range(511)));
        check("wrap_addr", int'(ram_addr), 400);

        // Resync at pixel index 1000.
        for (int i = 401; i < 1000; i++) send(1'b0, 9'($urandom_range(511)));
        e0 = dut_err; fd0 = dut_fd;
        send(1'b1, 9'h0AA);
        check("resync_err", int'(sof_err), 1);
        check("resync_addr", int'(ram_addr), 0);
        check("resync_rgb", int'({ram_red, ram_green, ram_blue}), 9'h0AA);
        tick();
        check("resync_err_pulse", int'(sof_err), 0);
        send(1'b0, 9'h055);
        check("resync_next_addr", int'(ram_addr), 1);
        check("resync_no_done", dut_fd - fd0, 0);
        check("resync_err_count", dut_err - e0, 1);

        // Asynchronous reset mid-stream while a write is on the port.
        sif.s_valid = 1'b1; enable = 1'b1;
        repeat (4) tick();
        check("pre_reset_we", int'(ram_we), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_we", int'(ram_we), 0);
        check("async_rst_ready", int'(sif.s_ready), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(frame_done), 0);
        check("async_rst_addr", int'(ram_addr), 0);
        sif.s_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Full frame, no backpressure.
        w0 = dut_wr; fd0 = dut_fd; rdy_low = 0; wr_in_frame = 0; chk401 = 1'b1;
        run_frame(100, 100);
        repeat (3) tick();
        chk401 = 1'b0;
        check("full_writes", dut_wr - w0, N);
        check("full_frame_done", dut_fd - fd0, 1);
        check("full_ready_low", rdy_low, 1);

        // Full frame with random enable/valid.
        w0 = dut_wr; fd0 = dut_fd;
        run_frame(50, 50);
        repeat (3) tick();
        check("bp_writes", dut_wr - w0, N);
        check("bp_frame_done", dut_fd - fd0, 1);

        // sof on the final pixel is a resync, not a completion.
        fd0 = dut_fd;
        send(1'b1, 9'($urandom_range(511)));
        for (int i = 1; i < N - 1; i++) send(1'b0, 9'($urandom_range(511)));
        send(1'b1, 9'h123);
        check("last_sof_err", int'(sof_err), 1);
        check("last_sof_addr", int'(ram_addr), 0);
        tick();
        check("last_sof_busy", int'(busy), 1);
        check("last_sof_no_done", dut_fd - fd0, 0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
